// File: rtl/lcd_pkg.sv
// Shared constants and state encoding for the character-LCD sequencer.
package lcd_pkg;

  localparam logic [7:0] LCD_FUNC_SET  = 8'h38;
  localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
  localparam logic [7:0] LCD_ENTRY     = 8'h06;
  localparam logic [7:0] LCD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_SET_DDRAM = 8'h80;
  localparam logic [7:0] LCD_LINE2_OFS = 8'h40;

  typedef enum logic [3:0] {
    ST_PWRUP,
    ST_INIT_FS,
    ST_INIT_DISP,
    ST_INIT_ENTRY,
    ST_INIT_CLR,
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_CLR
  } state_t;

  function automatic logic [7:0] ddram_addr(input logic row, input logic [3:0] col);
    return LCD_SET_DDRAM | (row ? LCD_LINE2_OFS : 8'h00) | {4'h0, col};
  endfunction

endpackage

// File: rtl/lcd_slot_timer.sv
// Bus-slot timer: counts 0..length-1 after a start pulse and produces the
// registered enable window plus a last-cycle strobe.
module lcd_slot_timer #(
  parameter int LEN_W = 8,
  parameter int T_SU  = 4,
  parameter int T_EN  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] length,
  output logic             en,
  output logic             last
);

  logic             busy, busy_nx;
  logic [LEN_W-1:0] cnt, cnt_nx;

  assign last = busy && (cnt == length - LEN_W'(1));

  always_comb begin
    busy_nx = busy;
    cnt_nx  = cnt;
    if (start) begin
      busy_nx = 1'b1;
      cnt_nx  = '0;
    end else if (busy) begin
      if (last) begin
        busy_nx = 1'b0;
        cnt_nx  = '0;
      end else begin
        cnt_nx = cnt + LEN_W'(1);
      end
    end
  end

  // en is computed from the next count so it lines up with the counter it describes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      en   <= 1'b0;
    end else begin
      busy <= busy_nx;
      cnt  <= cnt_nx;
      en   <= busy_nx && (cnt_nx >= LEN_W'(T_SU)) && (cnt_nx < LEN_W'(T_SU + T_EN));
    end
  end

endmodule

// File: rtl/text_lcd_sched.sv
// HD44780 init sequencer and write-bus arbiter for two character
// requesters and one clear requester.
module text_lcd_sched
  import lcd_pkg::*;
#(
  parameter int T_PWRUP = 70,
  parameter int T_CYC   = 30,
  parameter int T_SU    = 4,
  parameter int T_EN    = 8,
  parameter int T_CLR   = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       row0,
  input  logic [3:0] col0,
  input  logic [7:0] ch0,
  output logic       ack0,
  input  logic       req1,
  input  logic       row1,
  input  logic [3:0] col1,
  input  logic [7:0] ch1,
  output logic       ack1,
  input  logic       clr_req,
  output logic       clr_ack,
  output logic       ready,
  output logic       lcd_enb,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data
);

  localparam int LEN_W = $clog2(T_CLR + 1);
  localparam int PW_W  = $clog2(T_PWRUP + 1);

  state_t            state, state_nx;
  logic [PW_W-1:0]   pwr_cnt;
  logic              last_grant;
  logic [7:0]        ch_q;
  logic              start, slot_last;
  logic              grant0, grant1, grant_clr;
  logic [LEN_W-1:0]  slot_len;
  logic              sel_row;
  logic [3:0]        sel_col;
  logic [7:0]        sel_ch;
  logic              rs_nx;
  logic [7:0]        data_nx;

  assign slot_len = (state == ST_INIT_CLR || state == ST_CLR) ? LEN_W'(T_CLR) : LEN_W'(T_CYC);
  assign sel_row  = grant1 ? row1 : row0;
  assign sel_col  = grant1 ? col1 : col0;
  assign sel_ch   = grant1 ? ch1  : ch0;

  lcd_slot_timer #(.LEN_W(LEN_W), .T_SU(T_SU), .T_EN(T_EN)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .length (slot_len),
    .en     (lcd_enb),
    .last   (slot_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_PWRUP;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    start     = 1'b0;
    grant0    = 1'b0;
    grant1    = 1'b0;
    grant_clr = 1'b0;
    case (state)
      ST_PWRUP:      if (pwr_cnt == PW_W'(T_PWRUP - 1)) begin state_nx = ST_INIT_FS; start = 1'b1; end
      ST_INIT_FS:    if (slot_last) begin state_nx = ST_INIT_DISP;  start = 1'b1; end
      ST_INIT_DISP:  if (slot_last) begin state_nx = ST_INIT_ENTRY; start = 1'b1; end
      ST_INIT_ENTRY: if (slot_last) begin state_nx = ST_INIT_CLR;   start = 1'b1; end
      ST_INIT_CLR:   if (slot_last) state_nx = ST_IDLE;
      // Clear wins; with both requesters pending, serve the one not granted last
      ST_IDLE: begin
        if (clr_req) begin
          grant_clr = 1'b1;
          state_nx  = ST_CLR;
          start     = 1'b1;
        end else if (req0 && (!req1 || last_grant)) begin
          grant0   = 1'b1;
          state_nx = ST_ADDR;
          start    = 1'b1;
        end else if (req1) begin
          grant1   = 1'b1;
          state_nx = ST_ADDR;
          start    = 1'b1;
        end
      end
      ST_ADDR:       if (slot_last) begin state_nx = ST_DATA; start = 1'b1; end
      ST_DATA:       if (slot_last) state_nx = ST_IDLE;
      ST_CLR:        if (slot_last) state_nx = ST_IDLE;
      default:       state_nx = ST_PWRUP;
    endcase

    rs_nx   = lcd_rs;
    data_nx = lcd_data;
    if (start) begin
      case (state_nx)
        ST_INIT_FS:          begin rs_nx = 1'b0; data_nx = LCD_FUNC_SET; end
        ST_INIT_DISP:        begin rs_nx = 1'b0; data_nx = LCD_DISP_ON; end
        ST_INIT_ENTRY:       begin rs_nx = 1'b0; data_nx = LCD_ENTRY; end
        ST_INIT_CLR, ST_CLR: begin rs_nx = 1'b0; data_nx = LCD_CLEAR; end
        ST_ADDR:             begin rs_nx = 1'b0; data_nx = ddram_addr(sel_row, sel_col); end
        ST_DATA:             begin rs_nx = 1'b1; data_nx = ch_q; end
        default:             ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwr_cnt    <= '0;
      last_grant <= 1'b0;
      ch_q       <= 8'h00;
      ready      <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      clr_ack    <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_rw     <= 1'b0;
      lcd_data   <= 8'h00;
    end else begin
      if (state == ST_PWRUP) pwr_cnt <= pwr_cnt + PW_W'(1);
      if (grant0 || grant1) begin
        last_grant <= grant1;
        ch_q       <= sel_ch;
      end
      ready    <= ready || (state_nx == ST_IDLE);
      ack0     <= grant0;
      ack1     <= grant1;
      clr_ack  <= grant_clr;
      lcd_rs   <= rs_nx;
      lcd_rw   <= 1'b0;
      lcd_data <= data_nx;
    end
  end

endmodule
